// File: rtl/emac_tx_ctrl.sv
// emac_tx_ctrl: pops frame descriptors and bytes from the TX pointer/data FIFOs
// and drives a GMII byte stream (preamble, SFD, frame, inter-frame gap).
// Flagged or out-of-range frames are drained from the data FIFO and dropped.
// Optional statistics counters are built when TX_STAT_EN is defined.
module emac_tx_ctrl #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] tx_ptr_fifo_dout,
    input  logic        tx_ptr_fifo_empty,
    output logic        tx_ptr_fifo_rd,
    input  logic [7:0]  tx_data_fifo_dout,
    output logic        tx_data_fifo_rd,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
`ifdef TX_STAT_EN
    input  logic        stat_clr,
    output logic [31:0] stat_tx_frames,
    output logic [31:0] stat_tx_bytes,
    output logic [15:0] stat_drop_frames,
`endif
    output logic        busy,
    output logic        drop_pulse
);

    localparam int unsigned LEN_W = 11;
    localparam int unsigned CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        PTR_WAIT,
        PTR_LAT,
        PREAMBLE,
        SFD,
        DATA,
        IFG,
        DRAIN
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] cnt;

    logic [LEN_W-1:0] desc_len;
    logic             desc_bad;
    logic             frame_done;
    logic             drain_done;
    logic             unused_rsvd;

    // Descriptor decode and end-of-frame conditions
    assign desc_len    = tx_ptr_fifo_dout[10:0];
    assign desc_bad    = tx_ptr_fifo_dout[15] | tx_ptr_fifo_dout[14] |
                         (desc_len < LEN_W'(MIN_LEN)) | (desc_len > LEN_W'(MAX_LEN));
    assign frame_done  = (state == DATA)  && (cnt == len - CNT_W'(1));
    assign drain_done  = (state == DRAIN) && (cnt == len - CNT_W'(1));
    assign unused_rsvd = &{1'b0, tx_ptr_fifo_dout[13:11]};

    // Transmit FSM; strobes are registered so they are high while in their state,
    // GMII outputs are registered from the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            len             <= '0;
            cnt             <= '0;
            tx_ptr_fifo_rd  <= 1'b0;
            tx_data_fifo_rd <= 1'b0;
            gmii_tx_en      <= 1'b0;
            gmii_txd        <= 8'h00;
            busy            <= 1'b0;
            drop_pulse      <= 1'b0;
        end else begin
            tx_ptr_fifo_rd  <= 1'b0;
            tx_data_fifo_rd <= 1'b0;
            gmii_tx_en      <= 1'b0;
            gmii_txd        <= 8'h00;
            drop_pulse      <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_ptr_fifo_empty) begin
                        tx_ptr_fifo_rd <= 1'b1;
                        busy           <= 1'b1;
                        state          <= PTR_WAIT;
                    end
                end
                PTR_WAIT: begin
                    state <= PTR_LAT;
                end
                PTR_LAT: begin
                    len <= desc_len;
                    cnt <= '0;
                    if (!desc_bad) begin
                        state <= PREAMBLE;
                    end else if (desc_len == '0) begin
                        drop_pulse <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tx_data_fifo_rd <= 1'b1;
                        state           <= DRAIN;
                    end
                end
                PREAMBLE: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= 8'h55;
                    if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
                        cnt             <= '0;
                        tx_data_fifo_rd <= 1'b1;
                        state           <= SFD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SFD: begin
                    gmii_tx_en      <= 1'b1;
                    gmii_txd        <= 8'hD5;
                    tx_data_fifo_rd <= 1'b1;
                    state           <= DATA;
                end
                DATA: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_data_fifo_dout;
                    if (frame_done) begin
                        cnt   <= '0;
                        state <= IFG;
                    end else begin
                        cnt             <= cnt + CNT_W'(1);
                        tx_data_fifo_rd <= (cnt + CNT_W'(2) < len);
                    end
                end
                IFG: begin
                    if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        cnt        <= '0;
                        drop_pulse <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt             <= cnt + CNT_W'(1);
                        tx_data_fifo_rd <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_STAT_EN
    logic        drop_evt;
    logic [32:0] bytes_sum;

    assign drop_evt  = drain_done ||
                       ((state == PTR_LAT) && desc_bad && (desc_len == '0));
    assign bytes_sum = 33'(stat_tx_bytes) + 33'(len);

    // Saturating statistics counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_tx_frames   <= '0;
            stat_tx_bytes    <= '0;
            stat_drop_frames <= '0;
        end else begin
            if (frame_done && (stat_tx_frames != '1)) begin
                stat_tx_frames <= stat_tx_frames + 32'd1;
            end
            if (frame_done) begin
                stat_tx_bytes <= bytes_sum[32] ? '1 : bytes_sum[31:0];
            end
            if (drop_evt && (stat_drop_frames != '1)) begin
                stat_drop_frames <= stat_drop_frames + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_emac_tx_ctrl.sv
// tb_emac_tx_ctrl: directed bench for emac_tx_ctrl with FIFO models and a
// frame-level reference model (expected byte stream, lengths, reads, drops).
// Define TX_STAT_EN to also exercise the statistics counters.
module tb_emac_tx_ctrl;

    localparam int PRE  = 7;
    localparam int IFGC = 12;
    localparam int MINL = 64;
    localparam int MAXL = 1518;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ptr_dout  = 16'h0000;
    logic        ptr_empty = 1'b1;
    logic        ptr_rd;
    logic [7:0]  data_dout = 8'h00;
    logic        data_rd;
    logic        tx_en;
    logic [7:0]  txd;
    logic        busy;
    logic        drop_pulse;
`ifdef TX_STAT_EN
    logic        stat_clr = 1'b0;
    logic [31:0] st_frames;
    logic [31:0] st_bytes;
    logic [15:0] st_drops;
`endif

    emac_tx_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tx_ptr_fifo_dout (ptr_dout),
        .tx_ptr_fifo_empty(ptr_empty),
        .tx_ptr_fifo_rd   (ptr_rd),
        .tx_data_fifo_dout(data_dout),
        .tx_data_fifo_rd  (data_rd),
        .gmii_tx_en       (tx_en),
        .gmii_txd         (txd),
`ifdef TX_STAT_EN
        .stat_clr         (stat_clr),
        .stat_tx_frames   (st_frames),
        .stat_tx_bytes    (st_bytes),
        .stat_drop_frames (st_drops),
`endif
        .busy             (busy),
        .drop_pulse       (drop_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // FIFO models: standard read, dout valid the cycle after the read strobe
    logic [15:0] ptr_q[$];
    logic [7:0]  data_q[$];
    logic        ptr_rd_s  = 1'b0;
    logic        data_rd_s = 1'b0;

    always @(negedge clk) begin
        ptr_rd_s  = ptr_rd;
        data_rd_s = data_rd;
    end

    always @(posedge clk) begin
        if (ptr_rd_s && ptr_q.size() != 0) ptr_dout <= ptr_q.pop_front();
        if (data_rd_s && data_q.size() != 0) data_dout <= data_q.pop_front();
        ptr_empty <= (ptr_q.size() == 0);
    end

    // Reference model state filled by the stimulus
    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    int         exp_reads = 0;
    int         exp_drops = 0;
    logic [7:0] fb[$];

    // Monitor bookkeeping
    int          cyc = 0;
    int          rd_count = 0, drop_count = 0, frames_seen = 0;
    int          en_run = 0, low_run = 0, last_run = 0, last_gap = 0;
    int          last_ptr_cyc = 0, first_en_cyc = 0, last_drop_cyc = 0;
    bit          prev_en = 1'b0, had_frame = 1'b0;
    logic [31:0] tail = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: checks the GMII stream and strobes every cycle
    always @(negedge clk) begin
        if (rst) begin
            rd_count   = 0;
            drop_count = 0;
            en_run     = 0;
            low_run    = 0;
            prev_en    = 1'b0;
            had_frame  = 1'b0;
        end else begin
            if (ptr_rd) last_ptr_cyc = cyc;
            if (data_rd) begin
                rd_count++;
                check("data_fifo_has_byte_on_rd", 32'(data_q.size() != 0), 32'd1);
            end
            if (drop_pulse) begin
                drop_count++;
                last_drop_cyc = cyc;
            end
            if (tx_en || data_rd) check("busy_when_active", 32'(busy), 32'd1);
            if (tx_en) begin
                if (!prev_en) begin
                    first_en_cyc = cyc;
                    if (had_frame) begin
                        last_gap = low_run;
                        check("ifg_gap_at_least_15", 32'(low_run >= IFGC + 3), 32'd1);
                    end
                end
                en_run++;
                tail = {tail[23:0], txd};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx_en actual txd=0x%0h expected no transmission", txd);
                end else begin
                    check("txd", 32'(txd), 32'(exp_q.pop_front()));
                end
            end else begin
                check("txd_zero_when_idle", 32'(txd), 32'd0);
                if (prev_en) begin
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual run=%0d expected no frame", en_run);
                    end else begin
                        check("frame_en_cycles", 32'(en_run), 32'(exp_len_q.pop_front()));
                    end
                    frames_seen++;
                    had_frame = 1'b1;
                    last_run  = en_run;
                    low_run   = 0;
                    en_run    = 0;
                end
                low_run++;
            end
            prev_en = tx_en;
        end
    end

    task automatic build_pattern(input int len, input int seed);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(8'((seed + i * 7) & 255));
    endtask

    // Queue a frame into the FIFOs and derive its expected outcome
    task automatic send(input logic [15:0] desc);
        int len;
        bit good;
        len  = int'(desc[10:0]);
        good = !desc[15] && !desc[14] && len >= MINL && len <= MAXL;
        foreach (fb[i]) data_q.push_back(fb[i]);
        if (good) begin
            repeat (PRE) exp_q.push_back(8'h55);
            exp_q.push_back(8'hD5);
            foreach (fb[i]) exp_q.push_back(fb[i]);
            exp_len_q.push_back(len + PRE + 1);
        end else begin
            exp_drops++;
        end
        exp_reads += len;
        ptr_q.push_back(desc);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((ptr_q.size() != 0 || !ptr_empty || busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_en"}, 32'(tx_en), 32'd0);
        check({tag, "_txd"}, 32'(txd), 32'd0);
        check({tag, "_ptr_rd"}, 32'(ptr_rd), 32'd0);
        check({tag, "_data_rd"}, 32'(data_rd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(drop_pulse), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int base_rd, base_fr, base_dr, n;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single good frame with known header and tail
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(8'(8'hf0 + i));
        for (int i = 0; i < 6; i++) fb.push_back(8'(8'he0 + i));
        fb.push_back(8'h08);
        fb.push_back(8'h00);
        for (int i = 0; i < 86; i++) fb.push_back(8'(i));
        fb.push_back(8'h12);
        fb.push_back(8'h34);
        fb.push_back(8'h56);
        fb.push_back(8'h78);
        base_rd = rd_count;
        base_fr = frames_seen;
        send(16'h0068);
        wait_done(1000);
        check("t1_tx_en_cycles", 32'(last_run), 32'd112);
        check("t1_data_reads", 32'(rd_count - base_rd), 32'd104);
        check("t1_tail_bytes", tail, 32'h12345678);
        check("t1_first_preamble_latency", 32'(first_en_cyc - last_ptr_cyc), 32'd3);
        check("t1_frames", 32'(frames_seen - base_fr), 32'd1);

        // 2: two back-to-back frames
        base_fr = frames_seen;
        build_pattern(104, 3);
        send(16'h0068);
        build_pattern(104, 91);
        send(16'h0068);
        wait_done(1000);
        check("t2_frames", 32'(frames_seen - base_fr), 32'd2);
        check("t2_gap", 32'(last_gap >= 15), 32'd1);

        // 3: crc-flagged frame is drained, then a good frame
        base_rd = rd_count;
        base_fr = frames_seen;
        base_dr = drop_count;
        build_pattern(104, 17);
        send(16'h8068);
        wait_done(1000);
        check("t3_drop_count", 32'(drop_count - base_dr), 32'd1);
        check("t3_drain_reads", 32'(rd_count - base_rd), 32'd104);
        check("t3_no_tx", 32'(frames_seen - base_fr), 32'd0);
        check("t3_drop_timing", 32'(last_drop_cyc - last_ptr_cyc), 32'd106);
        build_pattern(104, 55);
        send(16'h0068);
        wait_done(1000);
        check("t3_good_after_drop", 32'(frames_seen - base_fr), 32'd1);

        // 4: length boundaries and length_error flag
        base_rd = rd_count;
        base_fr = frames_seen;
        base_dr = drop_count;
        build_pattern(63, 1);
        send(16'd63);
        build_pattern(1519, 2);
        send(16'd1519);
        build_pattern(64, 3);
        send(16'd64);
        build_pattern(1518, 4);
        send(16'd1518);
        build_pattern(104, 5);
        send(16'h4068);
        wait_done(8000);
        check("t4_frames", 32'(frames_seen - base_fr), 32'd2);
        check("t4_drops", 32'(drop_count - base_dr), 32'd3);
        check("t4_reads", 32'(rd_count - base_rd), 32'd3268);
        base_rd = rd_count;
        base_dr = drop_count;
        fb.delete();
        send(16'h0000);
        wait_done(100);
        check("t4_len0_drop", 32'(drop_count - base_dr), 32'd1);
        check("t4_len0_no_reads", 32'(rd_count - base_rd), 32'd0);
        check("t4_len0_drop_timing", 32'(last_drop_cyc - last_ptr_cyc), 32'd2);

        // 5: reset at data byte 50
        build_pattern(104, 77);
        send(16'h0068);
        n = 0;
        @(negedge clk);
        #1;
        while (!(tx_en && en_run == PRE + 1 + 51) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reached_byte50", 32'(n < 500), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("t5_after_rst");
        @(negedge clk);
        #1;
        ptr_q.delete();
        data_q.delete();
        exp_q.delete();
        exp_len_q.delete();
        exp_reads = 0;
        exp_drops = 0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_idle_tx_en", 32'(tx_en), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        base_fr = frames_seen;
        build_pattern(104, 200);
        send(16'h0068);
        wait_done(1000);
        check("t5_restart_frame", 32'(frames_seen - base_fr), 32'd1);
        check("t5_restart_reads", 32'(rd_count), 32'd104);

`ifdef TX_STAT_EN
        // 6: statistics counters
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("t6_clr_frames", st_frames, 32'd0);
        check("t6_clr_bytes", st_bytes, 32'd0);
        check("t6_clr_drops", 32'(st_drops), 32'd0);
        build_pattern(100, 10);
        send(16'd100);
        build_pattern(100, 20);
        send(16'h8064);
        build_pattern(100, 30);
        send(16'd100);
        build_pattern(100, 40);
        send(16'd100);
        wait_done(2000);
        check("t6_frames", st_frames, 32'd3);
        check("t6_bytes", st_bytes, 32'd300);
        check("t6_drops", 32'(st_drops), 32'd1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("t6_clr2_frames", st_frames, 32'd0);
        check("t6_clr2_bytes", st_bytes, 32'd0);
        check("t6_clr2_drops", 32'(st_drops), 32'd0);
`endif

        check("model_stream_drained", 32'(exp_q.size()), 32'd0);
        check("total_data_reads", 32'(rd_count), 32'(exp_reads));
        check("total_drops", 32'(drop_count), 32'(exp_drops));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
